// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Optional feature macro: HAZARD_FWD_EN (forwarding unit present).
package hazard_pkg;

   typedef logic [4:0] regbits_t;

   // Pipeline latch indices into the en/flush vectors
   localparam int IFID  = 0;
   localparam int IDEX  = 1;
   localparam int EXMEM = 2;
   localparam int MEMWB = 3;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DWAIT = 2'd1,
      DDONE = 2'd2,
      HALT  = 2'd3
   } hz_state_t;

   // A source operand conflicts with a writer only when it is really read,
   // names the same register, and that register is not $zero.
   function automatic logic src_match(input logic use_f, input regbits_t src,
                                      input regbits_t dst);
      return use_f && (src == dst) && (dst != 5'd0);
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// Source/destination register compare for the decode-stage instruction.
// HAZARD_FWD_EN defined: only a load in EX can stall (forwarding covers the
// rest). Undefined: any in-flight writer in EX, MEM or WB stalls decode.
module hazard_detect
   import hazard_pkg::*;
(
   input  logic [4:0] id_rs_i,
   input  logic [4:0] id_rt_i,
   input  logic       id_use_rs_i,
   input  logic       id_use_rt_i,
   input  logic       ex_regwr_i,
   input  logic       ex_memrd_i,
   input  logic [4:0] ex_wsel_i,
   input  logic       mem_regwr_i,
   input  logic [4:0] mem_wsel_i,
   input  logic       wb_regwr_i,
   input  logic [4:0] wb_wsel_i,
   output logic       raw_stall_o
);

   logic ex_hit;
   logic mem_hit;
   logic wb_hit;

   // Per-stage match of either decode source against that stage's destination
   always_comb begin
      ex_hit  = src_match(id_use_rs_i, id_rs_i, ex_wsel_i)
              | src_match(id_use_rt_i, id_rt_i, ex_wsel_i);
      mem_hit = src_match(id_use_rs_i, id_rs_i, mem_wsel_i)
              | src_match(id_use_rt_i, id_rt_i, mem_wsel_i);
      wb_hit  = src_match(id_use_rs_i, id_rs_i, wb_wsel_i)
              | src_match(id_use_rt_i, id_rt_i, wb_wsel_i);
   end

`ifdef HAZARD_FWD_EN
   // Load-use only: the loaded value is not available for forwarding yet
   logic unused_fwd_inputs;
   assign unused_fwd_inputs = mem_hit ^ wb_hit ^ mem_regwr_i ^ wb_regwr_i;
   assign raw_stall_o = ex_memrd_i & ex_regwr_i & ex_hit;
`else
   // No forwarding: wait until the writer has left WB, since the register
   // file does not bypass a same-cycle write to the read port
   logic unused_memrd;
   assign unused_memrd = ex_memrd_i;
   assign raw_stall_o = (ex_regwr_i & ex_hit)
                      | (mem_regwr_i & mem_hit)
                      | (wb_regwr_i & wb_hit);
`endif

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline controller: PC enable, latch enable/flush, cache-wait sequencing,
// halt and a saturating stall-cycle counter.
// Optional feature macro: HAZARD_FWD_EN (selects the hazard compare used).
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             mem_ren,
   input  logic             mem_wen,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic             ex_regwr,
   input  logic             ex_memrd,
   input  logic [4:0]       ex_wsel,
   input  logic             mem_regwr,
   input  logic [4:0]       mem_wsel,
   input  logic             wb_regwr,
   input  logic [4:0]       wb_wsel,
   input  logic             br_taken,
   input  logic             halt,
   output logic             pc_en,
   output logic [3:0]       en,
   output logic [3:0]       flush,
   output logic             mem_hold,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [1:0]       dbg_state
);

   hz_state_t        state_q, state_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic             memop;
   logic             advance;
   logic             raw_stall;

   hazard_detect u_detect (
      .id_rs_i     (id_rs),
      .id_rt_i     (id_rt),
      .id_use_rs_i (id_use_rs),
      .id_use_rt_i (id_use_rt),
      .ex_regwr_i  (ex_regwr),
      .ex_memrd_i  (ex_memrd),
      .ex_wsel_i   (ex_wsel),
      .mem_regwr_i (mem_regwr),
      .mem_wsel_i  (mem_wsel),
      .wb_regwr_i  (wb_regwr),
      .wb_wsel_i   (wb_wsel),
      .raw_stall_o (raw_stall)
   );

   // The pipeline moves when the fetch word is here and the MEM access (if any)
   // has completed, either this cycle or earlier (DDONE).
   assign memop   = mem_ren | mem_wen;
   assign advance = ihit & (~memop | dhit | (state_q == DDONE)) & (state_q != HALT);

   // Next-state logic for the cache-wait / halt sequencer
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN: begin
            if (memop && !dhit)
               state_d = DWAIT;
            else if (memop && dhit && !ihit)
               state_d = DDONE;
            else if (advance && halt)
               state_d = HALT;
         end
         DWAIT: begin
            if (dhit && ihit)
               state_d = halt ? HALT : RUN;
            else if (dhit)
               state_d = DDONE;
         end
         DDONE: begin
            if (ihit)
               state_d = halt ? HALT : RUN;
         end
         HALT:    state_d = HALT;
         default: state_d = RUN;
      endcase
   end

   // Enable/flush decode; branch squashes the stalled instruction, so it wins
   always_comb begin
      pc_en    = 1'b0;
      en       = 4'b0000;
      flush    = 4'b0000;
      mem_hold = 1'b0;
      halted   = 1'b0;
      if (nRST) begin
         mem_hold = (state_q == DDONE);
         halted   = (state_q == HALT);
         if (advance) begin
            if (br_taken) begin
               pc_en       = 1'b1;
               en          = 4'b1111;
               flush[IFID] = 1'b1;
               flush[IDEX] = 1'b1;
            end else if (raw_stall) begin
               en[IDEX]    = 1'b1;
               en[EXMEM]   = 1'b1;
               en[MEMWB]   = 1'b1;
               flush[IDEX] = 1'b1;
            end else begin
               pc_en = 1'b1;
               en    = 4'b1111;
            end
         end
      end
   end

   // Stall counter: cycles without a PC update outside HALT, saturating
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if ((state_q != HALT) && !pc_en && (stall_cnt_q != {CNT_W{1'b1}}))
         stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   // State and counter registers; reset abandons any pending cache wait
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q     <= RUN;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a vector table for the single-cycle decode
// plus hand-written sequences for cache waits, halt, reset and saturation.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int CW = 4;
  localparam logic [CW-1:0] MAXV = {CW{1'b1}};

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // Expected {pc_en, en[3:0], flush[3:0]}
  localparam logic [8:0] OK_O  = {1'b1, 4'b1111, 4'b0000};
  localparam logic [8:0] STL_O = {1'b0, 4'b1110, 4'b0010};
  localparam logic [8:0] BRF_O = {1'b1, 4'b1111, 4'b0011};
  localparam logic [8:0] NO_O  = 9'b0;

  logic CLK, nRST, ihit, dhit, mem_ren, mem_wen;
  logic [4:0] id_rs, id_rt, ex_wsel, mem_wsel, wb_wsel;
  logic id_use_rs, id_use_rt, ex_regwr, ex_memrd, mem_regwr, wb_regwr;
  logic br_taken, halt;
  logic pc_en, mem_hold, halted;
  logic [3:0] en, flush;
  logic [CW-1:0] stall_cnt;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [CW-1:0] exp_stall;

  typedef struct {
    logic [4:0] rs, rt;
    logic       urs, urt, exw, exl;
    logic [4:0] exd;
    logic       mw;
    logic [4:0] md;
    logic       ww;
    logic [4:0] wd;
    logic       br;
    logic [8:0] e_fwd, e_nofwd;
  } vec_t;
  vec_t vecs[12];

  hazard_ctrl #(.CNT_W(CW)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .mem_ren(mem_ren), .mem_wen(mem_wen),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_regwr(ex_regwr), .ex_memrd(ex_memrd), .ex_wsel(ex_wsel),
    .mem_regwr(mem_regwr), .mem_wsel(mem_wsel),
    .wb_regwr(wb_regwr), .wb_wsel(wb_wsel),
    .br_taken(br_taken), .halt(halt),
    .pc_en(pc_en), .en(en), .flush(flush), .mem_hold(mem_hold),
    .halted(halted), .stall_cnt(stall_cnt), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [8:0] pick(input logic [8:0] f, input logic [8:0] n);
    return FWD ? f : n;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic set_idle();
    ihit = 1'b1; dhit = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0;
    id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    ex_regwr = 1'b0; ex_memrd = 1'b0; ex_wsel = 5'd0;
    mem_regwr = 1'b0; mem_wsel = 5'd0; wb_regwr = 1'b0; wb_wsel = 5'd0;
    br_taken = 1'b0; halt = 1'b0;
  endtask

  // driver: check this cycle's combinational outputs, then clock once
  task automatic cyc(input string nm, input logic [8:0] e, input hz_state_t st);
    #2;
    chk({nm, "_pc"},    32'(pc_en),     32'(e[8]));
    chk({nm, "_en"},    32'(en),        32'(e[7:4]));
    chk({nm, "_flush"}, 32'(flush),     32'(e[3:0]));
    chk({nm, "_state"}, 32'(dbg_state), 32'(st));
    if (!e[8] && st != HALT && exp_stall != MAXV) exp_stall = exp_stall + 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    set_idle();
    @(posedge CLK); #1;
    nRST = 1'b1;
    exp_stall = '0;
  endtask

  // stimulus + scoreboard
  initial begin
    nRST = 1'b0;
    set_idle();
    exp_stall = '0;
    vecs[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0, 1'b0, 5'd0, 1'b0, OK_O,  OK_O};
    vecs[1]  = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5,  1'b0, 5'd0, 1'b0, 5'd0, 1'b0, STL_O, STL_O};
    vecs[2]  = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd5,  1'b0, 5'd0, 1'b0, 5'd0, 1'b0, OK_O,  STL_O};
    vecs[3]  = '{5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 5'd3, 1'b0, 5'd0, 1'b0, OK_O,  STL_O};
    vecs[4]  = '{5'd0, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0, 1'b1, 5'd7, 1'b0, OK_O,  STL_O};
    vecs[5]  = '{5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0,  1'b0, 5'd0, 1'b0, 5'd0, 1'b0, OK_O,  OK_O};
    vecs[6]  = '{5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5,  1'b0, 5'd0, 1'b0, 5'd0, 1'b0, OK_O,  OK_O};
    vecs[7]  = '{5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd9,  1'b0, 5'd0, 1'b0, 5'd0, 1'b0, OK_O,  OK_O};
    vecs[8]  = '{5'd0, 5'd9, 1'b0, 1'b1, 1'b1, 1'b1, 5'd9,  1'b0, 5'd0, 1'b0, 5'd0, 1'b1, BRF_O, BRF_O};
    vecs[9]  = '{5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd3, 1'b0, 5'd0, 1'b0, OK_O,  OK_O};
    vecs[10] = '{5'd0, 5'd12, 1'b0, 1'b1, 1'b1, 1'b1, 5'd12, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, STL_O, STL_O};
    vecs[11] = '{5'd4, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0,  1'b1, 5'd6, 1'b1, 5'd4, 1'b0, OK_O,  STL_O};

    // reset: outputs held low even with a pending memop
    mem_ren = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    chk("rst_pc", 32'(pc_en), 32'd0);
    chk("rst_en", 32'(en), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_hold", 32'(mem_hold), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(RUN));
    set_idle();
    nRST = 1'b1;

    // free running
    for (int i = 0; i < 10; i++) cyc($sformatf("idle%0d", i), OK_O, RUN);
    chk("idle_cnt", 32'(stall_cnt), 32'd0);

    // decode table
    for (int i = 0; i < 12; i++) begin
      set_idle();
      id_rs = vecs[i].rs; id_rt = vecs[i].rt;
      id_use_rs = vecs[i].urs; id_use_rt = vecs[i].urt;
      ex_regwr = vecs[i].exw; ex_memrd = vecs[i].exl; ex_wsel = vecs[i].exd;
      mem_regwr = vecs[i].mw; mem_wsel = vecs[i].md;
      wb_regwr = vecs[i].ww; wb_wsel = vecs[i].wd;
      br_taken = vecs[i].br;
      cyc($sformatf("vec%0d", i), pick(vecs[i].e_fwd, vecs[i].e_nofwd), RUN);
    end
    chk("vec_cnt", 32'(stall_cnt), 32'(exp_stall));

    // load r5 walks EX -> MEM -> WB while decode reads r5
    do_reset();
    set_idle(); id_rs = 5'd5; id_use_rs = 1'b1;
    ex_regwr = 1'b1; ex_memrd = 1'b1; ex_wsel = 5'd5;
    cyc("lu_ex", STL_O, RUN);
    ex_regwr = 1'b0; ex_memrd = 1'b0; ex_wsel = 5'd0;
    mem_regwr = 1'b1; mem_wsel = 5'd5;
    cyc("lu_mem", pick(OK_O, STL_O), RUN);
    mem_regwr = 1'b0; mem_wsel = 5'd0; wb_regwr = 1'b1; wb_wsel = 5'd5;
    cyc("lu_wb", pick(OK_O, STL_O), RUN);
    set_idle();
    cyc("lu_clr", OK_O, RUN);
    chk("lu_cnt", 32'(stall_cnt), FWD ? 32'd1 : 32'd3);

    // ALU writer r3 in MEM then WB
    do_reset();
    set_idle(); id_rs = 5'd3; id_use_rs = 1'b1; mem_regwr = 1'b1; mem_wsel = 5'd3;
    cyc("raw_mem", pick(OK_O, STL_O), RUN);
    mem_regwr = 1'b0; mem_wsel = 5'd0; wb_regwr = 1'b1; wb_wsel = 5'd3;
    cyc("raw_wb", pick(OK_O, STL_O), RUN);
    set_idle(); id_rs = 5'd3; id_use_rs = 1'b1;
    cyc("raw_done", OK_O, RUN);
    set_idle(); id_use_rs = 1'b1; ex_regwr = 1'b1; mem_regwr = 1'b1; wb_regwr = 1'b1;
    cyc("raw_r0", OK_O, RUN);
    chk("raw_cnt", 32'(stall_cnt), FWD ? 32'd0 : 32'd2);

    // dcache miss then icache miss
    do_reset();
    set_idle(); mem_ren = 1'b1; br_taken = 1'b1;
    cyc("dc_run", NO_O, RUN);
    br_taken = 1'b0;
    cyc("dc_w1", NO_O, DWAIT);
    cyc("dc_w2", NO_O, DWAIT);
    dhit = 1'b1; ihit = 1'b0;
    cyc("dc_w3", NO_O, DWAIT);
    dhit = 1'b0;
    #2 chk("dc_hold1", 32'(mem_hold), 32'd1);
    #0 cyc("dc_d1", NO_O, DDONE);
    ihit = 1'b1;
    #2 chk("dc_hold2", 32'(mem_hold), 32'd1);
    #0 cyc("dc_d2", OK_O, DDONE);
    mem_ren = 1'b0;
    cyc("dc_back", OK_O, RUN);
    chk("dc_cnt", 32'(stall_cnt), 32'd5);
    chk("dc_model", 32'(stall_cnt), 32'(exp_stall));

    // counter saturation
    do_reset();
    set_idle(); mem_ren = 1'b1;
    cyc("sat0", NO_O, RUN);
    for (int i = 1; i < 20; i++) cyc($sformatf("sat%0d", i), NO_O, DWAIT);
    chk("sat_cnt", 32'(stall_cnt), 32'(MAXV));
    chk("sat_model", 32'(stall_cnt), 32'(exp_stall));

    // halt, then reset out of it
    do_reset();
    set_idle(); halt = 1'b1;
    cyc("halt_adv", OK_O, RUN);
    halt = 1'b0; mem_ren = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2 chk($sformatf("halted%0d", i), 32'(halted), 32'd1);
      #0 cyc($sformatf("hlt%0d", i), NO_O, HALT);
    end
    chk("halt_cnt", 32'(stall_cnt), 32'd0);
    nRST = 1'b0;
    #1;
    chk("halt_rst_h", 32'(halted), 32'd0);
    chk("halt_rst_s", 32'(dbg_state), 32'(RUN));
    @(posedge CLK); #1;
    nRST = 1'b1; set_idle(); exp_stall = '0;
    cyc("halt_after", OK_O, RUN);

    // reset during DDONE abandons the access
    do_reset();
    set_idle(); mem_ren = 1'b1; dhit = 1'b1; ihit = 1'b0;
    cyc("ab_hit", NO_O, RUN);
    #2 chk("ab_ddone", 32'(dbg_state), 32'(DDONE));
    nRST = 1'b0;
    #1;
    chk("ab_state", 32'(dbg_state), 32'(RUN));
    chk("ab_hold", 32'(mem_hold), 32'd0);
    chk("ab_cnt", 32'(stall_cnt), 32'd0);
    @(posedge CLK); #1;
    nRST = 1'b1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
